// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/response and memory bus bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int NPORTS = 4,
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int IDW    = 4
);
    logic [NPORTS-1:0]    req_valid;
    logic [NPORTS-1:0]    req_ready;
    logic [NPORTS-1:0]    req_we;
    logic [NPORTS*AW-1:0] req_addr;
    logic [NPORTS*DW-1:0] req_wdata;
    logic [NPORTS-1:0]    rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic [IDW-1:0]       rsp_id;
    logic                 mem_cs;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;

    // Arbiter side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_id,
        output mem_cs, mem_we, mem_addr, mem_wdata
    );

    // Requesters plus memory side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_id,
        input  mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-port arbiter sharing one single-ported memory, one transaction in flight
// Round-robin by default; define ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module mem_port_arbiter #(
    parameter int NPORTS  = 4,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int IDW     = 4,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus
);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] next_id_q, next_id_d;
    logic           we_q, we_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [PW-1:0]  port_q, port_d;
    logic [IDW-1:0] id_q, id_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;

    logic              grant_found;
    logic [PW-1:0]     grant_idx;
    logic [NPORTS-1:0] ready_vec;
    logic              handshake;

    always_comb begin
        int sum;
        logic [PW-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = 0;
        idx         = '0;
        for (int i = 0; i < NPORTS; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            sum = i;
`else
            sum = (int'(rr_ptr_q) + i) % NPORTS;
`endif
            idx = PW'(sum);
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Grant is only offered in IDLE and is suppressed while reset is held.
    always_comb begin
        ready_vec = '0;
        if (state_q == IDLE && grant_found && !rst) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    assign handshake = |(bus.req_valid & ready_vec);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        next_id_d  = next_id_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        port_d     = port_q;
        id_d       = id_q;
        rdata_d    = rdata_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    we_d    = bus.req_we[grant_idx];
                    addr_d  = bus.req_addr[int'(grant_idx)*AW +: AW];
                    wdata_d = bus.req_wdata[int'(grant_idx)*DW +: DW];
                    port_d  = grant_idx;
                    id_d    = next_id_q;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == CW'(MEM_LAT - 1)) begin
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                next_id_d = next_id_q + 1'b1;
`ifndef ARB_FIXED_PRIO_EN
                rr_ptr_d  = (port_q == PW'(NPORTS - 1)) ? '0 : port_q + 1'b1;
`endif
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            next_id_q  <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            port_q     <= '0;
            id_q       <= '0;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            next_id_q  <= next_id_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            port_q     <= port_d;
            id_q       <= id_d;
            rdata_q    <= rdata_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        bus.req_ready = ready_vec;
        bus.mem_cs    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        bus.rsp_id    = '0;
        if (state_q == ACCESS) begin
            bus.mem_cs    = 1'b1;
            bus.mem_we    = we_q;
            bus.mem_addr  = addr_q;
            bus.mem_wdata = wdata_q;
        end
        if (state_q == RESP) begin
            bus.rsp_valid[port_q] = 1'b1;
            bus.rsp_rdata         = rdata_q;
            bus.rsp_id            = id_q;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (NPORTS=4, MEM_LAT=1)
module tb_mem_port_arbiter;
    localparam int NPORTS  = 4;
    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int IDW     = 4;
    localparam int MEM_LAT = 1;

    typedef struct {
        int             port;
        logic [IDW-1:0] id;
        logic [DW-1:0]  rdata;
        int             hs_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NPORTS(NPORTS), .AW(AW), .DW(DW), .IDW(IDW)) bus ();

    mem_port_arbiter #(
        .NPORTS(NPORTS), .AW(AW), .DW(DW), .IDW(IDW), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t           sb[$];
    int             grant_q[$];
    logic [IDW-1:0] rsp_ids[$];
    logic [DW-1:0]  rsp_data[$];
    logic [IDW-1:0] model_id = '0;
    logic [DW-1:0]  ref_mem   [logic [AW-1:0]];
    logic [DW-1:0]  mem_store [logic [AW-1:0]];
    logic [DW-1:0]  mem_rd_q = '0;
    exp_t           mon_e;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {16'hC0DE, a};
    endfunction

    // Memory model: read data appears the cycle after the chip-select cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_cs && bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_cs && !bus.mem_we)
            mem_rd_q <= mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr] : init_word(bus.mem_addr);
        else if (bus.mem_cs)
            mem_rd_q <= 32'hBAD0BAD0;
        else
            mem_rd_q <= 32'h5555AAAA;
    end
    assign bus.mem_rdata = mem_rd_q;

    always @(negedge clk) begin
        if (bus.rsp_valid != '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp rsp_valid=%b required none", bus.rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (bus.rsp_valid !== (NPORTS'(1) << mon_e.port)) begin
                    errors++;
                    $display("FAIL rsp_port rsp_valid=%b required port %0d", bus.rsp_valid, mon_e.port);
                end
                checks++;
                if (bus.rsp_id !== mon_e.id) begin
                    errors++;
                    $display("FAIL rsp_id got %0d required %0d", bus.rsp_id, mon_e.id);
                end
                checks++;
                if (bus.rsp_rdata !== mon_e.rdata) begin
                    errors++;
                    $display("FAIL rsp_rdata got %h required %h", bus.rsp_rdata, mon_e.rdata);
                end
                checks++;
                if (cyc - mon_e.hs_cyc != 2 + MEM_LAT) begin
                    errors++;
                    $display("FAIL rsp_latency got %0d required %0d", cyc - mon_e.hs_cyc, 2 + MEM_LAT);
                end
                rsp_ids.push_back(bus.rsp_id);
                rsp_data.push_back(bus.rsp_rdata);
            end
        end else begin
            checks++;
            if (bus.rsp_rdata !== '0 || bus.rsp_id !== '0) begin
                errors++;
                $display("FAIL idle_rsp_zero rdata=%h id=%0d required 0", bus.rsp_rdata, bus.rsp_id);
            end
        end
        checks++;
        if ($countones(bus.req_ready) > 1) begin
            errors++;
            $display("FAIL ready_onehot req_ready=%b required at most one bit", bus.req_ready);
        end
        if (!rst) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (bus.req_valid[p] && bus.req_ready[p]) begin
                    exp_t e;
                    logic [AW-1:0] a;
                    a        = bus.req_addr[p*AW +: AW];
                    e.port   = p;
                    e.id     = model_id;
                    e.hs_cyc = cyc;
                    if (bus.req_we[p]) begin
                        ref_mem[a] = bus.req_wdata[p*DW +: DW];
                        e.rdata    = '0;
                    end else begin
                        e.rdata = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
                    end
                    sb.push_back(e);
                    grant_q.push_back(p);
                    model_id = model_id + 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_we[p]              = we;
        bus.req_addr[p*AW +: AW]   = a;
        bus.req_wdata[p*DW +: DW]  = d;
        bus.req_valid[p]           = 1'b1;
    endtask

    task automatic wait_grants(input int n, input string name);
        int k;
        k = 0;
        while (grant_q.size() < n && k < 300) begin
            tick();
            k++;
        end
        if (grant_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s_grant_timeout grants=%0d required %0d", name, grant_q.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_rsp_timeout pending=%0d required 0", name, sb.size());
            sb.delete();
        end
        tick();
    endtask

    task automatic issue(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
        int target;
        target = grant_q.size() + 1;
        set_req(p, we, a, d);
        wait_grants(target, name);
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic clear_model();
        sb.delete();
        grant_q.delete();
        rsp_ids.delete();
        rsp_data.delete();
        model_id = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1'b0, 16'h0004, '0);
        tick();
        tick();
        checks++;
        if (bus.req_ready !== '0 || bus.mem_cs !== 1'b0 || bus.rsp_valid !== '0 ||
            bus.mem_addr !== '0 || bus.mem_we !== 1'b0 || bus.mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b cs=%b rsp=%b addr=%h required all 0",
                     bus.req_ready, bus.mem_cs, bus.rsp_valid, bus.mem_addr);
        end
        bus.req_valid = '0;
        clear_model();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        do_reset();
        issue(2, 1'b1, 16'h0010, 32'hDEADBEEF, "wr");
        wait_idle("wr");
        issue(1, 1'b0, 16'h0010, '0, "rd");
        wait_idle("rd");
        checks++;
        if (rsp_ids.size() != 2 || rsp_ids[0] !== 4'd0 || rsp_data[0] !== '0) begin
            errors++;
            $display("FAIL wr_rsp count=%0d id=%0d data=%h required 2/0/0",
                     rsp_ids.size(), rsp_ids.size() > 0 ? rsp_ids[0] : 4'hF, rsp_data.size() > 0 ? rsp_data[0] : '1);
        end
        checks++;
        if (rsp_ids.size() != 2 || rsp_ids[1] !== 4'd1 || rsp_data[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_rsp count=%0d required id 1 data deadbeef", rsp_ids.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < NPORTS; p++) set_req(p, 1'b0, AW'(16'h0100 + p), '0);
        wait_grants(4, "rr_all");
        bus.req_valid = '0;
        wait_idle("rr_all");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grant_q.size() < 4 || grant_q[i] != i) begin
                errors++;
                $display("FAIL rr_order slot %0d got %0d required %0d", i, grant_q.size() > i ? grant_q[i] : -1, i);
            end
            checks++;
            if (rsp_ids.size() < 4 || rsp_ids[i] !== IDW'(i)) begin
                errors++;
                $display("FAIL rr_ids slot %0d required id %0d", i, i);
            end
        end
        issue(1, 1'b0, 16'h0200, '0, "rr_wrap");
        bus.req_valid[0] = 1'b0;
        wait_idle("rr_wrap");
    endtask

    task automatic test_rr_priority();
        int base;
        issue(3, 1'b0, 16'h0300, '0, "p3");
        wait_idle("p3");
        base = grant_q.size();
        set_req(3, 1'b0, 16'h0303, '0);
        set_req(0, 1'b0, 16'h0300, '0);
        wait_grants(base + 1, "p0p3");
        bus.req_valid[0] = 1'b0;
        wait_grants(base + 2, "p0p3b");
        bus.req_valid[3] = 1'b0;
        wait_idle("p0p3");
        checks++;
        if (grant_q.size() < base + 2 || grant_q[base] != 0 || grant_q[base+1] != 3) begin
            errors++;
            $display("FAIL rr_after_p3 first=%0d second=%0d required 0 then 3",
                     grant_q.size() > base ? grant_q[base] : -1, grant_q.size() > base + 1 ? grant_q[base+1] : -1);
        end
    endtask

    task automatic test_pair_hold();
        int base;
        int want;
        base = grant_q.size();
        set_req(1, 1'b0, 16'h0401, '0);
        set_req(2, 1'b0, 16'h0402, '0);
        wait_grants(base + 4, "pair");
        bus.req_valid = '0;
        wait_idle("pair");
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            want = 1;
`else
            want = (i % 2 == 0) ? 1 : 2;
`endif
            checks++;
            if (grant_q.size() < base + 4 || grant_q[base+i] != want) begin
                errors++;
                $display("FAIL pair_order slot %0d got %0d required %0d", i,
                         grant_q.size() > base + i ? grant_q[base+i] : -1, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(0, 1'b0, 16'h0040, '0);
        wait_grants(17, "b2b");
        bus.req_valid = '0;
        wait_idle("b2b");
        checks++;
        if (rsp_ids.size() != 17) begin
            errors++;
            $display("FAIL b2b_count got %0d required 17", rsp_ids.size());
        end
        for (int i = 0; i < 17 && i < rsp_ids.size(); i++) begin
            checks++;
            if (rsp_ids[i] !== IDW'(i % 16)) begin
                errors++;
                $display("FAIL b2b_id slot %0d got %0d required %0d", i, rsp_ids[i], i % 16);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        issue(2, 1'b1, 16'h0050, 32'h12345678, "pre");
        wait_idle("pre");
        issue(2, 1'b0, 16'h0050, '0, "abort");
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_cs !== 1'b0 || bus.rsp_valid !== '0 || bus.req_ready !== '0) begin
            errors++;
            $display("FAIL reset_mid cs=%b rsp=%b ready=%b required 0", bus.mem_cs, bus.rsp_valid, bus.req_ready);
        end
        clear_model();
        set_req(1, 1'b0, 16'h0050, '0);
        set_req(3, 1'b0, 16'h0060, '0);
        tick();
        tick();
        tick();
        rst = 1'b0;
        base = grant_q.size();
        wait_grants(base + 1, "post_rst");
        bus.req_valid = '0;
        wait_idle("post_rst");
        checks++;
        if (grant_q.size() < 1 || grant_q[0] != 1) begin
            errors++;
            $display("FAIL post_rst_port got %0d required 1", grant_q.size() > 0 ? grant_q[0] : -1);
        end
        checks++;
        if (rsp_ids.size() != 1 || rsp_ids[0] !== 4'd0 || rsp_data[0] !== 32'h12345678) begin
            errors++;
            $display("FAIL post_rst_rsp count=%0d required one rsp id 0 data 12345678", rsp_ids.size());
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst = 1'b1;
        test_reset();
        test_write_read();
`ifndef ARB_FIXED_PRIO_EN
        test_round_robin();
        test_rr_priority();
`endif
        test_pair_hold();
        test_back_to_back();
        test_reset_mid();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
